// File: rtl/z8_mem_responder_if.sv
// rtl/z8_mem_responder_if.sv - fetch and data request/response bus for z8_mem_responder
interface z8_mem_responder_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [39:0] if_data;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic        dm_err;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  if_ack, if_data, if_err, dm_ack, dm_rdata, dm_err
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output if_ack, if_data, if_err, dm_ack, dm_rdata, dm_err
    );
endinterface

// File: rtl/z8_mem_responder.sv
// rtl/z8_mem_responder.sv - single-outstanding instruction/data memory responder; Z8_MEM_WAIT_EN adds wait states
module z8_mem_responder #(
    parameter int DATA_DEPTH  = 256,
    parameter int INSTR_DEPTH = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    z8_mem_responder_if.slave    bus,
    input  logic                 im_load_en,
    input  logic [15:0]          im_load_addr,
    input  logic [39:0]          im_load_data,
    output logic                 busy
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int IAW = $clog2(INSTR_DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
        $error("WAIT_CYCLES must be within 0..15");
    end

`ifdef Z8_MEM_WAIT_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    logic [3:0] wait_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
`endif

    state_t state, state_next;

    logic        sel_data;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;

    logic [15:0] dmem [DATA_DEPTH];
    logic [39:0] imem [INSTR_DEPTH];

    logic        if_ack_q, dm_ack_q, if_err_q, dm_err_q;
    logic [39:0] if_data_q;
    logic [15:0] dm_rdata_q;

    logic d_in_range, i_in_range, load_in_range, load_hit;
    logic [DAW-1:0] d_idx;
    logic [IAW-1:0] i_idx, load_idx;

    // Upper address bits only feed the range checks; the arrays never alias.
    assign d_in_range    = 32'(lat_addr) < DATA_DEPTH;
    assign i_in_range    = 32'(lat_addr) < INSTR_DEPTH;
    assign load_in_range = 32'(im_load_addr) < INSTR_DEPTH;
    assign d_idx         = lat_addr[DAW-1:0];
    assign i_idx         = lat_addr[IAW-1:0];
    assign load_idx      = im_load_addr[IAW-1:0];
    assign load_hit      = im_load_en && load_in_range && (im_load_addr == lat_addr);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.dm_req || bus.if_req) state_next = S_ACCESS;
`ifdef Z8_MEM_WAIT_EN
            S_ACCESS: state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:   if (wait_cnt == 4'd0) state_next = S_RESP;
`else
            S_ACCESS: state_next = S_RESP;
`endif
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

`ifdef Z8_MEM_WAIT_EN
    always_ff @(posedge clk) begin
        if (reset)                                    wait_cnt <= 4'd0;
        else if (state == S_ACCESS)                   wait_cnt <= WAIT_INIT;
        else if (state == S_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
    end
`endif

    // Data request wins a tie; the fetch requester keeps if_req high and is taken next.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_data  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 16'd0;
            lat_wdata <= 16'd0;
        end else if (state == S_IDLE && (bus.dm_req || bus.if_req)) begin
            sel_data  <= bus.dm_req;
            lat_we    <= bus.dm_req && bus.dm_we;
            lat_addr  <= bus.dm_req ? bus.dm_addr : bus.if_addr;
            lat_wdata <= bus.dm_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == S_RESP && sel_data && lat_we && d_in_range)
            dmem[d_idx] <= lat_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset && im_load_en && load_in_range)
            imem[load_idx] <= im_load_data;
    end

    // Response registers are cleared every cycle so data and error read 0 outside the ack pulse.
    always_ff @(posedge clk) begin
        if_ack_q   <= 1'b0;
        dm_ack_q   <= 1'b0;
        if_err_q   <= 1'b0;
        dm_err_q   <= 1'b0;
        if_data_q  <= 40'd0;
        dm_rdata_q <= 16'd0;
        if (!reset && state == S_RESP) begin
            if (sel_data) begin
                dm_ack_q   <= 1'b1;
                dm_err_q   <= !d_in_range;
                dm_rdata_q <= (d_in_range && !lat_we) ? dmem[d_idx] : 16'd0;
            end else begin
                if_ack_q  <= 1'b1;
                if_err_q  <= !i_in_range;
                if_data_q <= !i_in_range ? 40'd0 : (load_hit ? im_load_data : imem[i_idx]);
            end
        end
    end

    assign bus.if_ack   = if_ack_q;
    assign bus.if_err   = if_err_q;
    assign bus.if_data  = if_data_q;
    assign bus.dm_ack   = dm_ack_q;
    assign bus.dm_err   = dm_err_q;
    assign bus.dm_rdata = dm_rdata_q;

    // The ack cycle is still part of the transaction from the requester's view.
    assign busy = (state != S_IDLE) || if_ack_q || dm_ack_q;
endmodule

// File: tb/tb_z8_mem_responder.sv
// tb/tb_z8_mem_responder.sv - directed vector bench for z8_mem_responder
module tb_z8_mem_responder;
`ifdef Z8_MEM_WAIT_EN
    localparam int W = 3;
`else
    localparam int W = 0;
`endif
    localparam int LAT = 3 + W;

    logic        clk = 1'b0;
    logic        reset;
    logic        im_load_en;
    logic [15:0] im_load_addr;
    logic [39:0] im_load_data;
    logic        busy;

    z8_mem_responder_if bus();

    z8_mem_responder #(.DATA_DEPTH(256), .INSTR_DEPTH(256), .WAIT_CYCLES(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .im_load_en   (im_load_en),
        .im_load_addr (im_load_addr),
        .im_load_data (im_load_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } dvec_t;

    dvec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic data_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp_rdata, input logic exp_err, input string name);
        int  lat = 0;
        logic busy_ok = 1'b1;
        @(posedge clk); #1;
        bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
        @(posedge clk); #1;
        bus.dm_req = 1'b0; bus.dm_we = ~we; bus.dm_addr = ~addr; bus.dm_wdata = ~wdata;
        for (int c = 1; c <= LAT + 8; c++) begin
            @(negedge clk);
            busy_ok &= busy;
            if (bus.dm_ack) begin lat = c; break; end
        end
        check({name, " latency"}, 64'(lat), 64'(LAT));
        check({name, " busy"}, 64'(busy_ok), 64'd1);
        if (lat != 0) begin
            check({name, " dm_err"}, 64'(bus.dm_err), 64'(exp_err));
            if (!we) check({name, " dm_rdata"}, 64'(bus.dm_rdata), 64'(exp_rdata));
            @(negedge clk);
            check({name, " ack cleared"}, {bus.dm_ack, bus.dm_err, bus.dm_rdata}, 64'd0);
        end
    endtask

    task automatic fetch_txn(input logic [15:0] addr, input logic [39:0] exp_data, input logic exp_err,
                             input logic do_load, input logic [15:0] laddr, input logic [39:0] ldata,
                             input string name);
        int lat = 0;
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = addr;
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.if_addr = ~addr;
        for (int c = 1; c <= LAT + 8; c++) begin
            @(negedge clk);
            if (do_load && c == LAT - 1) begin
                im_load_en = 1'b1; im_load_addr = laddr; im_load_data = ldata;
            end else begin
                im_load_en = 1'b0;
            end
            if (bus.if_ack) begin lat = c; break; end
        end
        im_load_en = 1'b0;
        check({name, " latency"}, 64'(lat), 64'(LAT));
        if (lat != 0) begin
            check({name, " if_err"}, 64'(bus.if_err), 64'(exp_err));
            check({name, " if_data"}, 64'(bus.if_data), 64'(exp_data));
            @(negedge clk);
            check({name, " ack cleared"}, {bus.if_ack, bus.if_err, bus.if_data}, 64'd0);
        end
    endtask

    task automatic preload(input logic [15:0] addr, input logic [39:0] data);
        @(posedge clk); #1;
        im_load_en = 1'b1; im_load_addr = addr; im_load_data = data;
        @(posedge clk); #1;
        im_load_en = 1'b0;
    endtask

    initial begin
        int   dm_c, if_c;
        logic busy_ok, both, seen;

        vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 16'h0100, 16'h5555, 16'h0000, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
        vecs[5] = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
        vecs[6] = '{1'b1, 16'h00FF, 16'h7777, 16'h0000, 1'b0};
        vecs[7] = '{1'b0, 16'h00FF, 16'h0000, 16'h7777, 1'b0};
        vecs[8] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[9] = '{1'b1, 16'h0005, 16'h4321, 16'h0000, 1'b0};

        reset = 1'b1;
        im_load_en = 1'b0; im_load_addr = 16'd0; im_load_data = 40'd0;
        bus.if_req = 1'b0; bus.if_addr = 16'd0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 16'd0; bus.dm_wdata = 16'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset acks", {bus.if_ack, bus.dm_ack}, 64'd0);
        check("reset errs", {bus.if_err, bus.dm_err}, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset data", {bus.if_data, bus.dm_rdata}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            data_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
                     $sformatf("vec%0d", i));

        preload(16'd3, 40'h12_0000_00FF);
        preload(16'd4, 40'h00_0000_0044);
        fetch_txn(16'd3, 40'h12_0000_00FF, 1'b0, 1'b0, 16'd0, 40'd0, "fetch3");
        fetch_txn(16'h0100, 40'd0, 1'b1, 1'b0, 16'd0, 40'd0, "fetch oor");
        preload(16'h0103, 40'hFF_FFFF_FFFF);
        fetch_txn(16'd3, 40'h12_0000_00FF, 1'b0, 1'b0, 16'd0, 40'd0, "fetch3 after oor load");
        preload(16'd7, 40'h11_1111_1111);
        fetch_txn(16'd7, 40'h77_CAFE_0007, 1'b0, 1'b1, 16'd7, 40'h77_CAFE_0007, "fetch7 load priority");
        fetch_txn(16'd7, 40'h77_CAFE_0007, 1'b0, 1'b0, 16'd0, 40'd0, "fetch7 load kept");

        @(posedge clk); #1;
        reset = 1'b1; im_load_en = 1'b1; im_load_addr = 16'd4; im_load_data = 40'hDE_ADDE_ADDE;
        @(posedge clk); #1;
        reset = 1'b0; im_load_en = 1'b0;
        fetch_txn(16'd4, 40'h00_0000_0044, 1'b0, 1'b0, 16'd0, 40'd0, "load during reset");

        // simultaneous requests: data first, fetch held pending by its requester
        @(posedge clk); #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0010;
        bus.if_req = 1'b1; bus.if_addr = 16'd3;
        @(posedge clk); #1;
        bus.dm_req = 1'b0;
        dm_c = 0; if_c = 0; busy_ok = 1'b1; both = 1'b0;
        for (int c = 1; c <= 2 * LAT + 10; c++) begin
            @(negedge clk);
            busy_ok &= busy;
            both |= bus.dm_ack & bus.if_ack;
            if (bus.dm_ack && dm_c == 0) begin
                dm_c = c;
                check("dual dm_rdata", 64'(bus.dm_rdata), 64'hBEEF);
            end
            if (bus.if_ack) begin
                if_c = c;
                check("dual if_data", 64'(bus.if_data), 64'h12_0000_00FF);
                bus.if_req = 1'b0;
                break;
            end
        end
        bus.if_req = 1'b0;
        check("dual dm latency", 64'(dm_c), 64'(LAT));
        check("dual if latency", 64'(if_c), 64'(2 * LAT));
        check("dual busy", 64'(busy_ok), 64'd1);
        check("dual no overlap", 64'(both), 64'd0);

        // reset during ACCESS aborts the write to addr 5
        @(posedge clk); #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'd5; bus.dm_wdata = 16'h1234;
        @(posedge clk); #1;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < LAT + 6; c++) begin
            @(negedge clk);
            if (c == 0) check("abort busy", 64'(busy), 64'd0);
            seen |= bus.dm_ack;
        end
        check("abort no ack", 64'(seen), 64'd0);
        data_txn(1'b0, 16'd5, 16'd0, 16'h4321, 1'b0, "abort readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
